motor_pwm_multi: RTL



---
 rtl/motor_pwm_multi_pkg.sv | 16 +
 rtl/motor_pwm_multi_if.sv | 29 ++
 rtl/motor_pwm_multi_pwm_channel.sv | 135 +++++++++++++
 rtl/motor_pwm_multi.sv | 67 ++++++
 4 files changed

// File: rtl/motor_pwm_multi_pkg.sv
// Shared types and default constants for the multi-channel
// H-bridge PWM generator.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    RUN,
    DECEL,
    DEAD
  } ch_state_t;

  localparam int PERIOD_DEF    = 11000;
  localparam int CNT_W_DEF     = 14;
  localparam int RAMP_STEP_DEF = 500;
  localparam int DEAD_PER_DEF  = 2;

endpackage

// File: rtl/motor_pwm_multi_if.sv
// Control/bridge bundle between line-follower logic and the
// motor PWM block.
interface motor_pwm_multi_if
  import motor_pwm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                    en;
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH*CNT_W-1:0] speed;
  logic [NUM_CH-1:0]       brake;
  logic [NUM_CH-1:0]       out_a;
  logic [NUM_CH-1:0]       out_b;
  logic [NUM_CH*CNT_W-1:0] duty_cur;
  logic                    period_tick;

  modport master (
    output en, dir, speed, brake,
    input  out_a, out_b, duty_cur, period_tick
  );

  modport slave (
    input  en, dir, speed, brake,
    output out_a, out_b, duty_cur, period_tick
  );

endinterface

// File: rtl/motor_pwm_multi_pwm_channel.sv
// One H-bridge channel: reversal FSM, slew-limited duty and
// registered PWM compare with direction/brake output mapping.
module pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int DEAD_PER  = DEAD_PER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] cnt,
  input  logic             dir,
  input  logic [CNT_W-1:0] speed,
  input  logic             brake,
  output logic             out_a,
  output logic             out_b,
  output logic [CNT_W-1:0] duty
);

  localparam int DW =
    (DEAD_PER > 0) ? $clog2(DEAD_PER + 1) : 1;
  localparam logic [CNT_W-1:0] TOP = CNT_W'(PERIOD);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PER);

  ch_state_t        state, state_n;
  logic             dir_act, dir_n;
  logic [DW-1:0]    dead_cnt, dead_n;
  logic [CNT_W-1:0] duty_n;
  logic [CNT_W-1:0] target;
  logic             pwm;
  logic             a_n, b_n;

  // Step toward g without ever forming a sum above g.
  function automatic logic [CNT_W-1:0] ramp(
    input logic [CNT_W-1:0] d,
    input logic [CNT_W-1:0] g
  );
    logic [CNT_W-1:0] r;
    r = g;
    if (RAMP_STEP != 0) begin
      if (d < g && int'(g - d) > RAMP_STEP)
        r = d + CNT_W'(RAMP_STEP);
      else if (d > g && int'(d - g) > RAMP_STEP)
        r = d - CNT_W'(RAMP_STEP);
    end
    return r;
  endfunction

  always_comb begin
    target  = (speed > TOP) ? TOP : speed;
    pwm     = cnt < duty;
    state_n = state;
    dir_n   = dir_act;
    dead_n  = dead_cnt;
    duty_n  = duty;
    a_n     = pwm & dir_act;
    b_n     = pwm & ~dir_act;
    if (!en) begin
      state_n = RUN;
      dir_n   = dir;
      dead_n  = '0;
      duty_n  = '0;
      a_n     = 1'b0;
      b_n     = 1'b0;
    end else if (brake) begin
      state_n = RUN;
      dead_n  = '0;
      duty_n  = '0;
      a_n     = 1'b1;
      b_n     = 1'b1;
    end else if (tick) begin
      unique case (state)
        RUN: begin
          if (dir != dir_act) begin
            if (duty != '0) begin
              state_n = DECEL;
            end else if (DEAD_PER == 0) begin
              dir_n = dir;
            end else begin
              state_n = DEAD;
              dead_n  = DEAD_INIT;
            end
          end else begin
            duty_n = ramp(duty, target);
          end
        end
        DECEL: begin
          duty_n = ramp(duty, '0);
          if (duty_n == '0) begin
            if (DEAD_PER == 0) begin
              state_n = RUN;
              dir_n   = ~dir_act;
            end else begin
              state_n = DEAD;
              dead_n  = DEAD_INIT;
            end
          end
        end
        DEAD: begin
          if (dead_cnt <= DW'(1)) begin
            state_n = RUN;
            dir_n   = dir;
            dead_n  = '0;
          end else begin
            dead_n = dead_cnt - DW'(1);
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      dir_act  <= 1'b1;
      dead_cnt <= '0;
      duty     <= '0;
      out_a    <= 1'b0;
      out_b    <= 1'b0;
    end else begin
      state    <= state_n;
      dir_act  <= dir_n;
      dead_cnt <= dead_n;
      duty     <= duty_n;
      out_a    <= a_n;
      out_b    <= b_n;
    end
  end

endmodule

// File: rtl/motor_pwm_multi.sv
// Multi-channel H-bridge PWM generator: shared period counter
// plus one pwm_channel per motor.
module motor_pwm_multi
  import motor_pwm_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int DEAD_PER  = DEAD_PER_DEF
) (
  input logic               clk,
  input logic               rst,
  motor_pwm_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(PERIOD - 2);

  if (PERIOD < 2 || PERIOD >= 2**CNT_W) begin : g_bad_period
    $error("motor_pwm_multi: PERIOD out of range");
  end

  logic [CNT_W-1:0]        cnt;
  logic                    tick;
  logic [NUM_CH-1:0]       a;
  logic [NUM_CH-1:0]       b;
  logic [NUM_CH*CNT_W-1:0] duty;

  // tick is registered yet coincides with cnt == LAST.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .RAMP_STEP (RAMP_STEP),
      .DEAD_PER  (DEAD_PER)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.en),
      .tick  (tick),
      .cnt   (cnt),
      .dir   (bus.dir[i]),
      .speed (bus.speed[i*CNT_W +: CNT_W]),
      .brake (bus.brake[i]),
      .out_a (a[i]),
      .out_b (b[i]),
      .duty  (duty[i*CNT_W +: CNT_W])
    );
  end

  assign bus.out_a       = a;
  assign bus.out_b       = b;
  assign bus.duty_cur    = duty;
  assign bus.period_tick = tick;

endmodule
